// File: rtl/fetch_unit.sv
// Fetch stage: sequential PC generation, single-outstanding imem reads,
// and pushes of {pc, next_pc, instruction} into the instruction buffer.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        ins_full,
   output logic        wr_en,
   output logic [31:0] pc_out,
   output logic [31:0] next_pc_out,
   output logic [31:0] instruction_out,
   output logic        ins_flush
);

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_PUSH,
      S_DISCARD
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_pc_nxt;
   logic [31:0] hold_pc;
   logic [31:0] hold_pc_nxt;
   logic [31:0] hold_instr;
   logic [31:0] hold_instr_nxt;
   logic        req_hs;

   assign ins_flush     = redirect_valid;
   assign imem_req_addr = fetch_pc;
   assign req_hs        = imem_req_valid && imem_req_ready;

   assign pc_out          = reset ? 32'h0 : hold_pc;
   assign next_pc_out     = reset ? 32'h0 : hold_pc + 32'd4;
   assign instruction_out = reset ? 32'h0 : hold_instr;

   always_comb begin
      state_nxt      = state;
      fetch_pc_nxt   = fetch_pc;
      hold_pc_nxt    = hold_pc;
      hold_instr_nxt = hold_instr;
      imem_req_valid = 1'b0;
      wr_en          = 1'b0;
      if (!reset) begin
         unique case (state)
            S_REQ: begin
               imem_req_valid = 1'b1;
               if (req_hs) state_nxt = S_WAIT;
            end
            S_WAIT: begin
               if (imem_resp_valid) begin
                  hold_pc_nxt    = fetch_pc;
                  hold_instr_nxt = imem_resp_data;
                  state_nxt      = S_PUSH;
               end
            end
            S_PUSH: begin
               if (!ins_full && !redirect_valid) begin
                  wr_en        = 1'b1;
                  fetch_pc_nxt = fetch_pc + 32'd4;
                  state_nxt    = S_REQ;
               end
            end
            S_DISCARD: begin
               if (imem_resp_valid) state_nxt = S_REQ;
            end
            default: state_nxt = S_REQ;
         endcase
         // A redirect overrides everything; an accepted or pending
         // request leaves one stale response that must be drained.
         if (redirect_valid) begin
            fetch_pc_nxt   = {redirect_pc[31:2], 2'b00};
            hold_pc_nxt    = 32'h0;
            hold_instr_nxt = 32'h0;
            unique case (state)
               S_REQ:     state_nxt = req_hs ? S_DISCARD : S_REQ;
               S_WAIT:    state_nxt = imem_resp_valid ? S_REQ : S_DISCARD;
               S_PUSH:    state_nxt = S_REQ;
               S_DISCARD: state_nxt = imem_resp_valid ? S_REQ : S_DISCARD;
               default:   state_nxt = S_REQ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_REQ;
         fetch_pc   <= RESET_PC;
         hold_pc    <= 32'h0;
         hold_instr <= 32'h0;
      end else begin
         state      <= state_nxt;
         fetch_pc   <= fetch_pc_nxt;
         hold_pc    <= hold_pc_nxt;
         hold_instr <= hold_instr_nxt;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with a memory model
// and a PC-stream reference model.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        ins_full;
   logic        wr_en;
   logic [31:0] pc_out;
   logic [31:0] next_pc_out;
   logic [31:0] instruction_out;
   logic        ins_flush;

   fetch_unit #(.RESET_PC(RESET_PC)) dut (
      .clk(clk),
      .reset(reset),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid),
      .imem_resp_data(imem_resp_data),
      .ins_full(ins_full),
      .wr_en(wr_en),
      .pc_out(pc_out),
      .next_pc_out(next_pc_out),
      .instruction_out(instruction_out),
      .ins_flush(ins_flush)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [31:0] sb_q[$];
   logic [31:0] exp_req;
   logic [31:0] out_addr;
   bit          outstanding;
   bit          stale;
   bit          pending;
   bit          req_next;
   bit          done;
   bit          saw_wrap;
   bit          saw_zero;
   int          cnt;
   int          pushes;
   int          stale_drops;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0123_4567;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: compares every observed push against the scoreboard.
   always @(negedge clk) begin
      logic [31:0] e;
      if (!done) begin
         check("ins_flush", 32'(ins_flush), 32'(redirect_valid));
         if (reset) begin
            check("rst_req_valid", 32'(imem_req_valid), 32'd0);
            check("rst_wr_en", 32'(wr_en), 32'd0);
            check("rst_pc_out", pc_out, 32'd0);
            check("rst_next_pc", next_pc_out, 32'd0);
            check("rst_instr", instruction_out, 32'd0);
         end else begin
            if (req_next)
               check("req_present", 32'(imem_req_valid), 32'd1);
            if (imem_req_valid) begin
               check("req_addr", imem_req_addr, exp_req);
               check("one_outstanding", 32'(outstanding), 32'd0);
            end
            if (redirect_valid)
               check("redir_no_push", 32'(wr_en), 32'd0);
            else if (pending)
               check("push_when_room", 32'(wr_en), 32'(!ins_full));
            else
               check("no_spurious_push", 32'(wr_en), 32'd0);
            if (pending && ins_full && sb_q.size() > 0) begin
               check("stall_pc", pc_out, sb_q[0]);
               check("stall_instr", instruction_out, mem_word(sb_q[0]));
               check("stall_no_req", 32'(imem_req_valid), 32'd0);
            end
            if (wr_en) begin
               if (sb_q.size() == 0) begin
                  check("sb_nonempty", 32'd0, 32'd1);
               end else begin
                  e = sb_q.pop_front();
                  check("push_pc", pc_out, e);
                  check("push_next_pc", next_pc_out, e + 32'd4);
                  check("push_instr", instruction_out, mem_word(e));
                  pushes++;
                  if (e == 32'hFFFF_FFFC && next_pc_out == 32'h0)
                     saw_wrap = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      bit rs;
      bit hs;
      bit was_stale;
      bit rn;
      bit quiet;
      bit did_b1;
      bit did_b2;
      int lat_lo;
      int lat_hi;
      int full_cnt;
      int p1_pushes;
      int r;
      reset           = 1'b1;
      redirect_valid  = 1'b0;
      redirect_pc     = 32'h0;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      ins_full        = 1'b0;
      exp_req         = RESET_PC;
      full_cnt        = 0;
      did_b1          = 1'b0;
      did_b2          = 1'b0;
      p1_pushes       = 0;
      for (int c = -3; c < 2400; c++) begin
         @(posedge clk);
         #1;
         quiet  = (c < 40) || (c >= 80 && c < 120);
         lat_lo = (c >= 40 && c < 80) ? 4 : 1;
         lat_hi = (c >= 40 && c < 80) ? 4 : (quiet ? 1 : 5);
         reset  = (c < 0);
         imem_resp_valid = 1'b0;
         if (!reset && outstanding) begin
            if (cnt == 0) begin
               imem_resp_valid = 1'b1;
               imem_resp_data  = mem_word(out_addr);
            end else begin
               cnt--;
            end
         end
         if (quiet || (c >= 40 && c < 80)) begin
            imem_req_ready = 1'b1;
            ins_full       = 1'b0;
         end else begin
            imem_req_ready = ($urandom_range(3, 0) != 0);
            if (full_cnt > 0) begin
               ins_full = 1'b1;
               full_cnt--;
            end else begin
               ins_full = 1'b0;
               if ($urandom_range(7, 0) == 0)
                  full_cnt = $urandom_range(6, 1);
            end
         end
         redirect_valid = 1'b0;
         if (c == -2) begin
            redirect_valid = 1'b1;
            redirect_pc    = 32'h1234_5678;
         end else if (c >= 40 && c < 80) begin
            if (!did_b1 && outstanding && !imem_resp_valid && cnt == 1) begin
               redirect_valid = 1'b1;
               redirect_pc    = 32'h0000_1003;
               did_b1         = 1'b1;
            end else if (did_b1 && !did_b2 && c > 60 && !stale &&
                         imem_resp_valid) begin
               redirect_valid = 1'b1;
               redirect_pc    = 32'h0000_2000;
               did_b2         = 1'b1;
            end
         end else if (c == 80) begin
            redirect_valid = 1'b1;
            redirect_pc    = 32'hFFFF_FFFC;
         end else if (!quiet && $urandom_range(11, 0) == 0) begin
            redirect_valid = 1'b1;
            r = $urandom_range(3, 0);
            redirect_pc = (r == 0) ? 32'h0000_1003 :
                          (r == 1) ? 32'hFFFF_FFF8 : $urandom;
         end

         @(negedge clk);
         #2;
         if (c == 40) p1_pushes = pushes;
         if (reset) begin
            sb_q.delete();
            outstanding = 1'b0;
            stale       = 1'b0;
            pending     = 1'b0;
            req_next    = 1'b1;
            exp_req     = RESET_PC;
         end else begin
            rs        = imem_resp_valid;
            hs        = imem_req_valid && imem_req_ready;
            was_stale = stale;
            rn        = 1'b0;
            if (rs) begin
               outstanding = 1'b0;
               stale       = 1'b0;
               if (!was_stale && !redirect_valid) pending = 1'b1;
               if (was_stale) begin
                  rn = 1'b1;
                  stale_drops++;
               end
            end
            if (hs) begin
               sb_q.push_back(exp_req);
               if (exp_req == 32'h0) saw_zero = 1'b1;
               outstanding = 1'b1;
               stale       = 1'b0;
               cnt         = $urandom_range(lat_hi, lat_lo) - 1;
               out_addr    = exp_req;
               exp_req     = exp_req + 32'd4;
            end
            if (wr_en) begin
               pending = 1'b0;
               rn      = 1'b1;
            end
            if (imem_req_valid && !imem_req_ready) rn = 1'b1;
            if (redirect_valid) begin
               sb_q.delete();
               pending = 1'b0;
               exp_req = {redirect_pc[31:2], 2'b00};
               if (outstanding) stale = 1'b1;
               else rn = 1'b1;
            end
            req_next = rn;
         end
      end
      done = 1'b1;
      check("p1_throughput", 32'(p1_pushes >= 12), 32'd1);
      check("b_redirect_wait", 32'(did_b1), 32'd1);
      check("wrap_push", 32'(saw_wrap), 32'd1);
      check("wrap_req_zero", 32'(saw_zero), 32'd1);
      check("stale_dropped", 32'(stale_drops > 0), 32'd1);
      check("many_pushes", 32'(pushes > 200), 32'd1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
